// File: rtl/alu_operand_regfile_if.sv
// Bus bundle between the ALU datapath control and the operand register file:
// read ports, write-back port and ALU status capture.
interface alu_operand_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              rd_en;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              rd_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              flag_we;
    logic              alu_zero;
    logic              alu_cout;
    logic              alu_overflow;
    logic [2:0]        flags;
    logic              ovf_sticky;
    logic              ovf_clr;

    modport master (
        output rd_en, rs_addr, rt_addr,
        output wr_en, wr_addr, wr_data,
        output flag_we, alu_zero, alu_cout, alu_overflow, ovf_clr,
        input  rs_data, rt_data, rd_valid, flags, ovf_sticky
    );

    modport slave (
        input  rd_en, rs_addr, rt_addr,
        input  wr_en, wr_addr, wr_data,
        input  flag_we, alu_zero, alu_cout, alu_overflow, ovf_clr,
        output rs_data, rt_data, rd_valid, flags, ovf_sticky
    );
endinterface

// File: rtl/alu_operand_regfile.sv
// Architectural register file feeding ALU src1/src2 through registered read
// ports, with ALU result write-back, status flag capture and sticky overflow.
module alu_operand_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input logic                   clk,
    input logic                   rst,
    alu_operand_regfile_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rs_q, rs_d;
    logic [DATA_W-1:0] rt_q, rt_d;
    logic              valid_q, valid_d;
    logic [2:0]        flags_q, flags_d;
    logic              sticky_q, sticky_d;

    logic wr_go;
    logic rs_hit;
    logic rt_hit;

    // r0 is never written, so a hit implies a nonzero read address.
    assign wr_go  = bus.wr_en && (bus.wr_addr != '0);
    assign rs_hit = (BYPASS != 0) && wr_go && (bus.wr_addr == bus.rs_addr);
    assign rt_hit = (BYPASS != 0) && wr_go && (bus.wr_addr == bus.rt_addr);

    always_comb begin
        rs_d    = rs_q;
        rt_d    = rt_q;
        valid_d = 1'b0;
        if (bus.rd_en) begin
            valid_d = 1'b1;
            if (bus.rs_addr == '0) begin
                rs_d = '0;
            end else if (rs_hit) begin
                rs_d = bus.wr_data;
            end else begin
                rs_d = mem_q[bus.rs_addr];
            end
            if (bus.rt_addr == '0) begin
                rt_d = '0;
            end else if (rt_hit) begin
                rt_d = bus.wr_data;
            end else begin
                rt_d = mem_q[bus.rt_addr];
            end
        end
    end

    always_comb begin
        flags_d  = flags_q;
        if (bus.flag_we) begin
            flags_d = {bus.alu_overflow, bus.alu_cout, bus.alu_zero};
        end
        // A capture in the same cycle as a clear leaves the bit set.
        sticky_d = (sticky_q & ~bus.ovf_clr) | (bus.flag_we & bus.alu_overflow);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_go) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_q     <= '0;
            rt_q     <= '0;
            valid_q  <= 1'b0;
            flags_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            valid_q  <= valid_d;
            flags_q  <= flags_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.rs_data    = rs_q;
    assign bus.rt_data    = rt_q;
    assign bus.rd_valid   = valid_q;
    assign bus.flags      = flags_q;
    assign bus.ovf_sticky = sticky_q;
endmodule

// File: tb/tb_alu_operand_regfile.sv
// Drives a write-first and a read-first register file with identical stimulus
// and compares both against an array-based reference model every cycle.
module tb_alu_operand_regfile;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        rd_en, wr_en, flag_we, alu_zero, alu_cout, alu_overflow, ovf_clr;
    logic [4:0]  rs_addr, rt_addr, wr_addr;
    logic [31:0] wr_data;

    alu_operand_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
    alu_operand_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();

    assign bus1.rd_en = rd_en;           assign bus0.rd_en = rd_en;
    assign bus1.rs_addr = rs_addr;       assign bus0.rs_addr = rs_addr;
    assign bus1.rt_addr = rt_addr;       assign bus0.rt_addr = rt_addr;
    assign bus1.wr_en = wr_en;           assign bus0.wr_en = wr_en;
    assign bus1.wr_addr = wr_addr;       assign bus0.wr_addr = wr_addr;
    assign bus1.wr_data = wr_data;       assign bus0.wr_data = wr_data;
    assign bus1.flag_we = flag_we;       assign bus0.flag_we = flag_we;
    assign bus1.alu_zero = alu_zero;     assign bus0.alu_zero = alu_zero;
    assign bus1.alu_cout = alu_cout;     assign bus0.alu_cout = alu_cout;
    assign bus1.alu_overflow = alu_overflow; assign bus0.alu_overflow = alu_overflow;
    assign bus1.ovf_clr = ovf_clr;       assign bus0.ovf_clr = ovf_clr;

    alu_operand_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_wf (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    alu_operand_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_rf (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    // Reference state: register contents plus expected registered outputs.
    logic [31:0] model [32];
    logic [31:0] e_rs1, e_rt1, e_rs0, e_rt0;
    logic        e_valid, e_sticky;
    logic [2:0]  e_flags;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    endtask

    task automatic idle();
        rst = 0; rd_en = 0; wr_en = 0; flag_we = 0; ovf_clr = 0;
        alu_zero = 0; alu_cout = 0; alu_overflow = 0;
        rs_addr = 0; rt_addr = 0; wr_addr = 0; wr_data = 0;
    endtask

    function automatic logic [31:0] rd_old(input logic [4:0] a);
        return (a == 0) ? 32'h0 : model[a];
    endfunction

    // Predict the effect of the inputs currently applied, clock once, compare.
    task automatic cycle();
        if (rst) begin
            foreach (model[i]) model[i] = 32'h0;
            e_rs1 = 0; e_rt1 = 0; e_rs0 = 0; e_rt0 = 0;
            e_valid = 0; e_flags = 0; e_sticky = 0;
        end else begin
            e_valid = rd_en;
            if (rd_en) begin
                e_rs0 = rd_old(rs_addr);
                e_rt0 = rd_old(rt_addr);
                e_rs1 = (wr_en && wr_addr != 0 && wr_addr == rs_addr) ? wr_data : e_rs0;
                e_rt1 = (wr_en && wr_addr != 0 && wr_addr == rt_addr) ? wr_data : e_rt0;
            end
            if (wr_en && wr_addr != 0) model[wr_addr] = wr_data;
            if (flag_we) e_flags = {alu_overflow, alu_cout, alu_zero};
            e_sticky = (flag_we && alu_overflow) ? 1'b1 : (ovf_clr ? 1'b0 : e_sticky);
        end
        @(posedge clk);
        #1;
        check("wf_rs_data", bus1.rs_data, e_rs1);
        check("wf_rt_data", bus1.rt_data, e_rt1);
        check("rf_rs_data", bus0.rs_data, e_rs0);
        check("rf_rt_data", bus0.rt_data, e_rt0);
        check("wf_rd_valid", {31'h0, bus1.rd_valid}, {31'h0, e_valid});
        check("rf_rd_valid", {31'h0, bus0.rd_valid}, {31'h0, e_valid});
        check("wf_flags", {29'h0, bus1.flags}, {29'h0, e_flags});
        check("rf_flags", {29'h0, bus0.flags}, {29'h0, e_flags});
        check("wf_sticky", {31'h0, bus1.ovf_sticky}, {31'h0, e_sticky});
        check("rf_sticky", {31'h0, bus0.ovf_sticky}, {31'h0, e_sticky});
    endtask

    initial begin
        foreach (model[i]) model[i] = 32'h0;
        e_rs1 = 0; e_rt1 = 0; e_rs0 = 0; e_rt0 = 0;
        e_valid = 0; e_flags = 0; e_sticky = 0;
        idle();
        rst = 1; cycle(); cycle();

        // Reset clears contents; a write in the reset cycle is dropped.
        idle(); wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; cycle();
        idle(); rst = 1; wr_en = 1; wr_addr = 6; wr_data = 32'h0BADF00D; cycle();
        idle(); rd_en = 1; rs_addr = 5; rt_addr = 6; cycle();
        check("reset_r5", bus1.rs_data, 32'h0);
        check("reset_r6", bus1.rt_data, 32'h0);

        // Basic write then read.
        idle(); wr_en = 1; wr_addr = 3; wr_data = 32'h12345678; cycle();
        idle(); wr_en = 1; wr_addr = 7; wr_data = 32'hFFFFFFFF; cycle();
        idle(); rd_en = 1; rs_addr = 3; rt_addr = 7; cycle();
        check("basic_rs", bus1.rs_data, 32'h12345678);
        check("basic_rt", bus0.rt_data, 32'hFFFFFFFF);
        idle(); cycle();

        // Register 0 is hardwired, including same-cycle write+read.
        idle(); wr_en = 1; wr_addr = 0; wr_data = 32'hAAAA5555; cycle();
        idle(); rd_en = 1; rs_addr = 0; rt_addr = 0; cycle();
        idle(); rd_en = 1; rs_addr = 0; rt_addr = 0;
        wr_en = 1; wr_addr = 0; wr_data = 32'hAAAA5555; cycle();
        check("r0_bypass", bus1.rs_data, 32'h0);

        // Forwarding on both ports from one write.
        idle(); wr_en = 1; wr_addr = 9; wr_data = 32'h1; cycle();
        idle(); wr_en = 1; wr_addr = 9; wr_data = 32'h2; rd_en = 1; rs_addr = 9; rt_addr = 9; cycle();
        check("fwd_wf_rs", bus1.rs_data, 32'h2);
        check("fwd_wf_rt", bus1.rt_data, 32'h2);
        check("fwd_rf_rs", bus0.rs_data, 32'h1);
        check("fwd_rf_rt", bus0.rt_data, 32'h1);
        idle(); rd_en = 1; rs_addr = 9; rt_addr = 9; cycle();
        check("fwd_rf_next", bus0.rs_data, 32'h2);

        // Flags capture/hold and sticky overflow.
        idle(); flag_we = 1; alu_zero = 1; alu_cout = 1; cycle();
        check("flags_011", {29'h0, bus1.flags}, 32'h3);
        idle(); alu_overflow = 1; cycle();
        check("flags_hold", {29'h0, bus1.flags}, 32'h3);
        idle(); flag_we = 1; alu_overflow = 1; cycle();
        check("sticky_set", {31'h0, bus1.ovf_sticky}, 32'h1);
        idle(); ovf_clr = 1; flag_we = 1; alu_overflow = 1; cycle();
        check("sticky_set_wins", {31'h0, bus1.ovf_sticky}, 32'h1);
        idle(); ovf_clr = 1; cycle();
        check("sticky_clr", {31'h0, bus0.ovf_sticky}, 32'h0);

        // Randomized traffic on a narrow address window to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            idle();
            rst          = ($urandom_range(0, 63) == 0);
            rd_en        = $urandom_range(0, 1);
            rs_addr      = 5'($urandom_range(0, 7));
            rt_addr      = 5'($urandom_range(0, 7));
            wr_en        = $urandom_range(0, 1);
            wr_addr      = 5'($urandom_range(0, 7));
            wr_data      = $urandom;
            flag_we      = $urandom_range(0, 1);
            alu_zero     = $urandom_range(0, 1);
            alu_cout     = $urandom_range(0, 1);
            alu_overflow = ($urandom_range(0, 3) == 0);
            ovf_clr      = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
